// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the writeback port arbiter:
//   - writeback mux select encodings (one per requester)
//   - arbiter state enum
//   - the architectural zero register index
//   - helpers for walking requester indices in round-robin order
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Burst counter width; large enough for MAX_BURST up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BURST
    } arb_state_t;

    // Next requester index in the 0 -> 1 -> 2 -> 0 cycle.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == SEL_LINK) ? SEL_ALU : idx + 2'd1;
    endfunction

    // Requester index to writeback mux select.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        logic [1:0] s;
        case (idx)
            2'd0:    s = SEL_ALU;
            2'd1:    s = SEL_MEM;
            2'd2:    s = SEL_LINK;
            default: s = SEL_ALU;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick3.sv
// -----------------------------------------------------------------------------
// rr_pick3
// Combinational three-way round-robin picker. The search starts at the index
// after ptr and wraps, so ptr is the most recently served requester.
//
// Ports:
//   req   in  3  request vector
//   ptr   in  2  last served index (0..2)
//   gnt   out 3  one-hot grant (zero when nothing requests)
//   idx   out 2  index of the granted requester
//   found out 1  a grant was produced
// -----------------------------------------------------------------------------
module rr_pick3
    import wb_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;

    assign c1 = rr_next(ptr);
    assign c2 = rr_next(c1);
    assign c3 = rr_next(c2);

    always_comb begin
        gnt   = '0;
        idx   = c1;
        found = 1'b0;
        if (req[c1]) begin
            gnt   = 3'b001 << c1;
            idx   = c1;
            found = 1'b1;
        end else if (req[c2]) begin
            gnt   = 3'b001 << c2;
            idx   = c2;
            found = 1'b1;
        end else if (req[c3]) begin
            gnt   = 3'b001 << c3;
            idx   = c3;
            found = 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register-file write port between three writeback requesters
// (0 = ALU, 1 = memory load, 2 = link/PC+8). Each cycle at most one requester
// is granted; all outputs are registered, so a request sampled at edge N is
// answered during cycle N+1.
//
// Default build: round-robin arbitration with an optional burst lock. A
// granted requester holding lock keeps the port for up to MAX_BURST
// consecutive grants, then yields to the next pending requester (if any).
//
// Build option WB_ARB_FIXED_PRIO_EN: fixed priority 1 > 0 > 2, no burst
// lock, busy tied low.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   req      in   3   per-requester write request, held until acked
//   lock     in   3   per-requester burst-lock hint (qualified by req)
//   addr0..2 in   AW  destination register per requester
//   ack      out  3   one-hot grant pulse
//   sel      out  2   writeback mux select (holds when no grant)
//   wr_en    out  1   register-file write enable (low for $zero)
//   wr_addr  out  AW  register-file write address
//   busy     out  1   burst lock in progress
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 4,
    parameter int AW        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic [AW-1:0]    addr0,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    output logic [N_REQ-1:0] ack,
    output logic [1:0]       sel,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic             busy
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic [1:0]       ptr_q;     // last granted index
    logic [1:0]       ptr_d;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gidx;
    logic             any;

    logic [2:0]       pick_req;
    logic [1:0]       pick_ptr;
    logic [2:0]       pick_gnt;
    logic [1:0]       pick_idx;
    logic             pick_found;

    logic [AW-1:0]    gaddr;

    rr_pick3 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        case (gidx)
            2'd0:    gaddr = addr0;
            2'd1:    gaddr = addr1;
            2'd2:    gaddr = addr2;
            default: gaddr = addr0;
        endcase
    end

`ifdef WB_ARB_FIXED_PRIO_EN

    // Permute the request vector so that a round-robin search starting after
    // pointer 2 visits requester 1, then 0, then 2. The picked slot is mapped
    // back to the real requester index below.
    assign pick_req = {req[2], req[0], req[1]};
    assign pick_ptr = 2'd2;

    always_comb begin
        state_d = IDLE;
        gnt     = '0;
        gidx    = ptr_q;
        any     = 1'b0;
        if (pick_found) begin
            any     = 1'b1;
            state_d = GRANT;
            case (pick_idx)
                2'd0:    gidx = 2'd1;
                2'd1:    gidx = 2'd0;
                default: gidx = 2'd2;
            endcase
            gnt = 3'b001 << gidx;
        end
    end

    assign ptr_d = any ? gidx : ptr_q;

    logic busy_d;
    assign busy_d = 1'b0;

    logic unused_fixed;
    assign unused_fixed = ^{lock, pick_gnt};

`else

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hold;
    logic             at_max;
    logic             force_rot;
    logic             busy_d;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    // The burst owner is always the last granted index, so ptr_q names it.
    assign hold      = (state_q == BURST) && req[ptr_q] && lock[ptr_q];
    assign at_max    = (cnt_q == MAX_CNT);
    assign force_rot = hold && at_max;

    // On forced rotation the owner is masked out so the picker lands on the
    // next pending requester; if none is left the owner simply continues.
    assign pick_req = force_rot ? (req & ~(3'b001 << ptr_q)) : req;
    assign pick_ptr = ptr_q;

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt     = '0;
        gidx    = ptr_q;
        any     = 1'b0;
        if (hold && !at_max) begin
            gnt     = 3'b001 << ptr_q;
            gidx    = ptr_q;
            any     = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = BURST;
        end else if (force_rot) begin
            any = 1'b1;
            if (pick_found) begin
                gnt     = pick_gnt;
                gidx    = pick_idx;
                state_d = GRANT;
            end else begin
                gnt     = 3'b001 << ptr_q;
                gidx    = ptr_q;
                cnt_d   = CNT_W'(1);
                state_d = BURST;
            end
        end else if (pick_found) begin
            // Covers a fresh grant and also a burst owner that dropped req or
            // lock: the search resumes after the owner.
            gnt  = pick_gnt;
            gidx = pick_idx;
            any  = 1'b1;
            if (lock[pick_idx]) begin
                cnt_d   = CNT_W'(1);
                state_d = BURST;
            end else begin
                state_d = GRANT;
            end
        end
    end

    assign ptr_d  = any ? gidx : ptr_q;
    assign busy_d = (state_d == BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer resets to 2 so requester 0 is first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 2'd2;
            ack     <= '0;
            sel     <= SEL_ALU;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            busy    <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ack   <= gnt;
            wr_en <= any && (gaddr != AW'(REG_ZERO));
            busy  <= busy_d;
            if (any) begin
                sel     <= idx_to_sel(gidx);
                wr_addr <= gaddr;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Table-driven bench for wb_port_arbiter plus a hand-written reset-mid-burst
// sequence. Vectors run back to back; each row lists the inputs applied
// before a clock edge and the registered outputs expected after it.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [4:0] addr0;
    logic [4:0] addr1;
    logic [4:0] addr2;
    logic [2:0] ack;
    logic [1:0] sel;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] lock;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [2:0] ack;
        logic [1:0] sel;
        logic       we;
        logic [4:0] wa;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    wb_port_arbiter #(
        .N_REQ     (3),
        .MAX_BURST (4),
        .AW        (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .addr0   (addr0),
        .addr1   (addr1),
        .addr2   (addr2),
        .ack     (ack),
        .sel     (sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] l,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [2:0] eack,
                                input logic [1:0] esel, input logic ewe,
                                input logic [4:0] ewa, input logic ebusy);
        vec_t v;
        v.req = r;  v.lock = l;
        v.a0 = a0;  v.a1 = a1;  v.a2 = a2;
        v.ack = eack; v.sel = esel; v.we = ewe; v.wa = ewa; v.busy = ebusy;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [2:0] eack,
                             input logic [1:0] esel, input logic ewe,
                             input logic [4:0] ewa, input logic ebusy);
        cmp({nm, " ack"},     32'(ack),     32'(eack));
        cmp({nm, " sel"},     32'(sel),     32'(esel));
        cmp({nm, " wr_en"},   32'(wr_en),   32'(ewe));
        cmp({nm, " wr_addr"}, 32'(wr_addr), 32'(ewa));
        cmp({nm, " busy"},    32'(busy),    32'(ebusy));
        cmp({nm, " onehot"},  32'($onehot0(ack)), 32'd1);
        cmp({nm, " sel_ok"},  32'(sel != 2'b11),  32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef WB_ARB_FIXED_PRIO_EN
        //          req     lock    a0 a1 a2  ack     sel    we    wa  busy
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b010, 2'b01, 1'b1, 5'd6, 1'b0));
        vecs.push_back(mk(3'b111, 3'b111, 5, 6, 7, 3'b010, 2'b01, 1'b1, 5'd6, 1'b0));
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b010, 2'b01, 1'b1, 5'd6, 1'b0));
        vecs.push_back(mk(3'b101, 3'b000, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b0));
        vecs.push_back(mk(3'b100, 3'b100, 5, 6, 7, 3'b100, 2'b10, 1'b1, 5'd7, 1'b0));
        vecs.push_back(mk(3'b110, 3'b110, 5, 0, 7, 3'b010, 2'b01, 1'b0, 5'd0, 1'b0));
        vecs.push_back(mk(3'b000, 3'b000, 5, 6, 7, 3'b000, 2'b01, 1'b0, 5'd0, 1'b0));
`else
        // Plain round-robin rotation with all three requesting.
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b0));
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b010, 2'b01, 1'b1, 5'd6, 1'b0));
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b100, 2'b10, 1'b1, 5'd7, 1'b0));
        vecs.push_back(mk(3'b111, 3'b000, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b0));
        // Idle: sel and wr_addr hold, wr_en low.
        vecs.push_back(mk(3'b000, 3'b000, 5, 6, 7, 3'b000, 2'b00, 1'b0, 5'd5, 1'b0));
        // Write to $zero: acked and selected but not written.
        vecs.push_back(mk(3'b010, 3'b000, 5, 0, 7, 3'b010, 2'b01, 1'b0, 5'd0, 1'b0));
        vecs.push_back(mk(3'b000, 3'b000, 5, 6, 7, 3'b000, 2'b01, 1'b0, 5'd0, 1'b0));
        // Burst: owner 0 for four grants, forced hand-off to 1, back to 0.
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b010, 2'b01, 1'b1, 5'd6, 1'b0));
        vecs.push_back(mk(3'b011, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        // Owner 0 drops lock after its second grant; 2 is next.
        vecs.push_back(mk(3'b101, 3'b001, 5, 6, 7, 3'b001, 2'b00, 1'b1, 5'd5, 1'b1));
        vecs.push_back(mk(3'b101, 3'b000, 5, 6, 7, 3'b100, 2'b10, 1'b1, 5'd7, 1'b0));
        vecs.push_back(mk(3'b000, 3'b000, 5, 6, 7, 3'b000, 2'b10, 1'b0, 5'd7, 1'b0));
        // Lone owner at the burst limit keeps the port with a fresh count.
        vecs.push_back(mk(3'b001, 3'b001, 9, 6, 7, 3'b001, 2'b00, 1'b1, 5'd9, 1'b1));
        vecs.push_back(mk(3'b001, 3'b001, 9, 6, 7, 3'b001, 2'b00, 1'b1, 5'd9, 1'b1));
        vecs.push_back(mk(3'b001, 3'b001, 9, 6, 7, 3'b001, 2'b00, 1'b1, 5'd9, 1'b1));
        vecs.push_back(mk(3'b001, 3'b001, 9, 6, 7, 3'b001, 2'b00, 1'b1, 5'd9, 1'b1));
        vecs.push_back(mk(3'b001, 3'b001, 9, 6, 7, 3'b001, 2'b00, 1'b1, 5'd9, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 9, 6, 7, 3'b000, 2'b00, 1'b0, 5'd9, 1'b0));
`endif

        rst   = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;
        addr0 = 5'd5;
        addr1 = 5'd6;
        addr2 = 5'd7;
        #12;
        check_all("reset", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            req   = vecs[i].req;
            lock  = vecs[i].lock;
            addr0 = vecs[i].a0;
            addr1 = vecs[i].a1;
            addr2 = vecs[i].a2;
            tick();
            check_all($sformatf("v%0d", i), vecs[i].ack, vecs[i].sel,
                      vecs[i].we, vecs[i].wa, vecs[i].busy);
        end

`ifndef WB_ARB_FIXED_PRIO_EN
        // Reset in the middle of a burst owned by requester 1.
        req   = 3'b110;
        lock  = 3'b010;
        addr0 = 5'd5;
        addr1 = 5'd6;
        addr2 = 5'd7;
        tick();
        check_all("burst1_a", 3'b010, 2'b01, 1'b1, 5'd6, 1'b1);
        tick();
        check_all("burst1_b", 3'b010, 2'b01, 1'b1, 5'd6, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_all("midrst", 3'b000, 2'b00, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        lock = 3'b000;
        tick();
        check_all("after_rst", 3'b010, 2'b01, 1'b1, 5'd6, 1'b0);
        tick();
        check_all("after_rst2", 3'b100, 2'b10, 1'b1, 5'd7, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
